// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Encodings shared by the decoder, the MEM stage and writeback.
//             This covers the result-source select codes and the load funct3
//             codes.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;

  // Writeback result source select. Code 2'b11 is reserved and decodes as ALU.
  localparam logic [1:0] RESULT_ALU  = 2'b00;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

  // Load width/sign codes (funct3 of the load instructions).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
//  Module   : load_ext
//  Purpose  : Picks the addressed byte or halfword out of a word-aligned load
//             word and sign- or zero-extends it. This block is purely
//             combinational.
//  Revision : 1.0  initial release
// ============================================================================
module load_ext
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection. Alignment is guaranteed upstream, so a halfword only
  // looks at off[1].
  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extension by load type. Unknown codes fall back to the full word.
  always_comb begin
    ext_o = word_i;
    case (funct3_i)
      F3_LB:   ext_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext_o = {{(XLEN-16){1'b0}}, half_sel};
      default: ext_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : MEM/WB pipeline register plus writeback. It drives the regfile
//             write port, provides an ID-stage write-through bypass, and
//             counts retired instructions.
//  Revision : 1.0  initial release
// ============================================================================
module wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_reg_write,
  input  logic [4:0]       m_rd,
  input  logic [1:0]       m_result_src,
  input  logic [2:0]       m_funct3,
  input  logic [XLEN-1:0]  m_alu_result,
  input  logic [XLEN-1:0]  m_read_data,
  input  logic [XLEN-1:0]  m_pc_plus4,
  input  logic [4:0]       id_a1,
  input  logic [4:0]       id_a2,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  output logic [4:0]       a3,
  output logic [XLEN-1:0]  wd3,
  output logic             WriteEn,
  output logic [XLEN-1:0]  byp_rd1,
  output logic [XLEN-1:0]  byp_rd2,
  output logic [CNT_W-1:0] instret
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic            w_valid_q,  w_valid_d;
  logic            w_rw_q,     w_rw_d;
  logic [4:0]      w_rd_q,     w_rd_d;
  logic [1:0]      w_src_q,    w_src_d;
  logic [2:0]      w_f3_q,     w_f3_d;
  logic [XLEN-1:0] w_alu_q,    w_alu_d;
  logic [XLEN-1:0] w_rdata_q,  w_rdata_d;
  logic [XLEN-1:0] w_pc4_q,    w_pc4_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0] load_val;

  // W register next state. Flush beats stall, and stall beats load.
  // Reset is applied in the flop.
  always_comb begin
    w_valid_d = w_valid_q;
    w_rw_d    = w_rw_q;
    w_rd_d    = w_rd_q;
    w_src_d   = w_src_q;
    w_f3_d    = w_f3_q;
    w_alu_d   = w_alu_q;
    w_rdata_d = w_rdata_q;
    w_pc4_d   = w_pc4_q;
    if (flush) begin
      w_valid_d = 1'b0;
      w_rw_d    = 1'b0;
      w_rd_d    = '0;
      w_src_d   = '0;
      w_f3_d    = '0;
      w_alu_d   = '0;
      w_rdata_d = '0;
      w_pc4_d   = '0;
    end else if (!stall) begin
      w_valid_d = m_valid;
      w_rw_d    = m_reg_write;
      w_rd_d    = m_rd;
      w_src_d   = m_result_src;
      w_f3_d    = m_funct3;
      w_alu_d   = m_alu_result;
      w_rdata_d = m_read_data;
      w_pc4_d   = m_pc_plus4;
    end
  end

  // An entry retires when it leaves W normally. Entries that are held or
  // flushed do not count.
  always_comb begin
    instret_d = instret_q;
    if (w_valid_q && !stall && !flush) instret_d = instret_q + CNT_ONE;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_q <= 1'b0;
      w_rw_q    <= 1'b0;
      w_rd_q    <= '0;
      w_src_q   <= '0;
      w_f3_q    <= '0;
      w_alu_q   <= '0;
      w_rdata_q <= '0;
      w_pc4_q   <= '0;
      instret_q <= '0;
    end else begin
      w_valid_q <= w_valid_d;
      w_rw_q    <= w_rw_d;
      w_rd_q    <= w_rd_d;
      w_src_q   <= w_src_d;
      w_f3_q    <= w_f3_d;
      w_alu_q   <= w_alu_d;
      w_rdata_q <= w_rdata_d;
      w_pc4_q   <= w_pc4_d;
      instret_q <= instret_d;
    end
  end

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3_i (w_f3_q),
    .off_i    (w_alu_q[1:0]),
    .word_i   (w_rdata_q),
    .ext_o    (load_val)
  );

  // Writeback mux and regfile port. The reserved source code selects ALU.
  always_comb begin
    case (w_src_q)
      RESULT_LOAD: wd3 = load_val;
      RESULT_PC4:  wd3 = w_pc4_q;
      default:     wd3 = w_alu_q;
    endcase
    a3      = w_rd_q;
    WriteEn = w_valid_q & w_rw_q & (w_rd_q != 5'd0);
  end

  // Write-through bypass. The regfile's async read cannot see this cycle's
  // write, so the bypass supplies it.
  always_comb begin
    byp_rd1 = (WriteEn && (id_a1 == a3)) ? wd3 : id_rd1;
    byp_rd2 = (WriteEn && (id_a2 == a3)) ? wd3 : id_rd2;
  end

  assign instret = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Self-checking bench for wb_stage. It uses directed vectors,
//             corner-case sequences, and random traffic against a reference
//             model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, m_valid, m_reg_write;
  logic [4:0]  m_rd, id_a1, id_a2;
  logic [1:0]  m_result_src;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_result, m_read_data, m_pc_plus4, id_rd1, id_rd2;
  logic [4:0]  a3;
  logic [31:0] wd3, byp_rd1, byp_rd2;
  logic        WriteEn;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
    .m_result_src(m_result_src), .m_funct3(m_funct3),
    .m_alu_result(m_alu_result), .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
    .id_a1(id_a1), .id_a2(id_a2), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .a3(a3), .wd3(wd3), .WriteEn(WriteEn), .byp_rd1(byp_rd1), .byp_rd2(byp_rd2),
    .instret(instret)
  );

  // Register file written by the DUT's write port.
  logic [31:0] rf [32];
  always @(posedge clk) if (WriteEn) rf[a3] <= wd3;

  // Reference model: the instruction currently in writeback, plus a retire count.
  typedef struct {
    bit valid; bit rw; int unsigned rd; int unsigned src; int unsigned f3;
    bit [31:0] alu; bit [31:0] rdata; bit [31:0] pc4;
  } winst_t;
  winst_t     mw;
  bit [63:0]  mcnt;

  function automatic bit [31:0] model_value(winst_t w);
    int unsigned off, b, h;
    off = w.alu % 4;
    b = (w.rdata >> (8 * off)) & 32'hFF;
    h = (w.rdata >> (16 * (off / 2))) & 32'hFFFF;
    if (w.src == 1) begin
      case (w.f3)
        0: return (b >= 128) ? b - 256 : b;
        4: return b;
        1: return (h >= 32768) ? h - 65536 : h;
        5: return h;
        default: return w.rdata;
      endcase
    end
    if (w.src == 2) return w.pc4;
    return w.alu;
  endfunction

  function automatic bit model_we(winst_t w);
    return w.valid && w.rw && w.rd != 0;
  endfunction

  task automatic model_edge();
    winst_t z;
    z = '{default: 0};
    if (reset) begin
      mw = z; mcnt = 0;
    end else if (flush) begin
      mw = z;
    end else if (!stall) begin
      if (mw.valid) mcnt = mcnt + 1;
      mw.valid = m_valid; mw.rw = m_reg_write; mw.rd = m_rd; mw.src = m_result_src;
      mw.f3 = m_funct3; mw.alu = m_alu_result; mw.rdata = m_read_data; mw.pc4 = m_pc_plus4;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit [31:0] v;
    bit we;
    v = model_value(mw);
    we = model_we(mw);
    chk("model_we", {63'd0, WriteEn}, {63'd0, we});
    chk("model_a3", {59'd0, a3}, 64'(mw.rd));
    chk("model_wd3", {32'd0, wd3}, {32'd0, v});
    chk("model_byp1", {32'd0, byp_rd1}, {32'd0, (we && id_a1 == mw.rd) ? v : id_rd1});
    chk("model_byp2", {32'd0, byp_rd2}, {32'd0, (we && id_a2 == mw.rd) ? v : id_rd2});
    chk("model_instret", instret, mcnt);
  endtask

  // One clock: advance the model at the edge, then check just after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive_m(bit v, bit rw, logic [4:0] rd, logic [1:0] src, logic [2:0] f3,
                         logic [31:0] alu, logic [31:0] rdata, logic [31:0] pc4);
    m_valid = v; m_reg_write = rw; m_rd = rd; m_result_src = src; m_funct3 = f3;
    m_alu_result = alu; m_read_data = rdata; m_pc_plus4 = pc4;
  endtask

  typedef struct {
    logic [4:0] rd; logic [1:0] src; logic [2:0] f3;
    logic [31:0] alu; logic [31:0] rdata; logic [31:0] pc4;
    logic exp_we; logic [31:0] exp_wd3; logic [31:0] exp_byp1;
  } vec_t;
  vec_t vecs[10];

  bit [63:0] base;

  initial begin
    vecs[0] = '{5'd5, 2'b00, 3'b000, 32'h12345678, 32'h0, 32'h0, 1'b1, 32'h12345678, 32'h0};
    vecs[1] = '{5'd6, 2'b01, 3'b000, 32'h00001003, 32'h80FF7F01, 32'h0, 1'b1, 32'hFFFFFF80, 32'h0};
    vecs[2] = '{5'd6, 2'b01, 3'b100, 32'h00001003, 32'h80FF7F01, 32'h0, 1'b1, 32'h00000080, 32'h0};
    vecs[3] = '{5'd6, 2'b01, 3'b001, 32'h00001002, 32'h80FF7F01, 32'h0, 1'b1, 32'hFFFF80FF, 32'h0};
    vecs[4] = '{5'd6, 2'b01, 3'b101, 32'h00001000, 32'h80FF7F01, 32'h0, 1'b1, 32'h00007F01, 32'h0};
    vecs[5] = '{5'd6, 2'b01, 3'b010, 32'h00001000, 32'h80FF7F01, 32'h0, 1'b1, 32'h80FF7F01, 32'h0};
    vecs[6] = '{5'd0, 2'b00, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[7] = '{5'd7, 2'b00, 3'b000, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[8] = '{5'd1, 2'b10, 3'b000, 32'h00000055, 32'h0, 32'h104, 1'b1, 32'h00000104, 32'h0};
    vecs[9] = '{5'd2, 2'b11, 3'b000, 32'h00000077, 32'h1, 32'h2, 1'b1, 32'h00000077, 32'h0};

    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    mw = '{default: 0}; mcnt = 0;
    reset = 1; stall = 0; flush = 0;
    id_a1 = 5'd7; id_a2 = 5'd8; id_rd1 = 32'h0; id_rd2 = 32'h13572468;
    drive_m(1, 1, 5'd9, 2'b00, 3'b000, 32'hCAFEF00D, 32'h0, 32'h0);
    tick();
    chk("reset_we", {63'd0, WriteEn}, 64'd0);
    chk("reset_a3", {59'd0, a3}, 64'd0);
    chk("reset_wd3", {32'd0, wd3}, 64'd0);
    chk("reset_instret", instret, 64'd0);
    reset = 0;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 10; i++) begin
      drive_m(1, 1, vecs[i].rd, vecs[i].src, vecs[i].f3, vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
      tick();
      chk($sformatf("vec%0d_we", i), {63'd0, WriteEn}, {63'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_wd3", i), {32'd0, wd3}, {32'd0, vecs[i].exp_wd3});
      chk($sformatf("vec%0d_a3", i), {59'd0, a3}, {59'd0, vecs[i].rd});
      chk($sformatf("vec%0d_byp1", i), {32'd0, byp_rd1}, {32'd0, vecs[i].exp_byp1});
      chk($sformatf("vec%0d_byp2", i), {32'd0, byp_rd2}, 64'h13572468);
      if (i == 1) chk("rf_x5", {32'd0, rf[5]}, 64'h12345678);
      if (i == 7) chk("rf_x0", {32'd0, rf[0]}, 64'd0);
    end
    chk("instret_after_vecs", instret, 64'd9);

    // JAL held for three stall cycles. The write value holds and it is counted once.
    drive_m(1, 1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h104);
    tick();
    base = instret;
    stall = 1;
    drive_m(1, 1, 5'd3, 2'b00, 3'b000, 32'h99, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_wd3", {32'd0, wd3}, 64'h104);
      chk("stall_we", {63'd0, WriteEn}, 64'd1);
      chk("stall_instret", instret, base);
    end
    stall = 0; m_valid = 0;
    tick();
    chk("stall_release_instret", instret, base + 64'd1);

    // Flush with stall: the bubble wins and there is no count.
    drive_m(1, 1, 5'd4, 2'b00, 3'b000, 32'h44, 32'h0, 32'h0);
    tick();
    base = instret;
    stall = 1; flush = 1;
    tick();
    chk("flush_we", {63'd0, WriteEn}, 64'd0);
    chk("flush_instret", instret, base);
    stall = 0; flush = 0; m_valid = 0;
    tick();
    chk("flush_after_instret", instret, base);

    // Reset during a valid write.
    drive_m(1, 1, 5'd10, 2'b00, 3'b000, 32'h1010, 32'h0, 32'h0);
    tick();
    reset = 1;
    tick();
    chk("midreset_we", {63'd0, WriteEn}, 64'd0);
    chk("midreset_instret", instret, 64'd0);
    chk("midreset_wd3", {32'd0, wd3}, 64'd0);
    reset = 0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      drive_m($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      id_a1 = $urandom_range(0, 1) ? m_rd : 5'(mw.rd);
      id_a2 = 5'($urandom_range(0, 31));
      id_rd1 = $urandom; id_rd2 = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
